// File: rtl/beat_cnt_pkg.sv
// Shared definitions for the multi-channel beat counter and the FSMs that
// drive its mode input.
package beat_cnt_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_SAT     = 2'd0,
    MODE_WRAP    = 2'd1,
    MODE_ONESHOT = 2'd2,
    MODE_RSVD    = 2'd3
  } cnt_mode_e;

endpackage : beat_cnt_pkg

// File: rtl/beat_cnt_ch.sv
// One beat-counter channel: counts qualified beats up to a latched terminal
// count in saturating, wrapping or one-shot mode.
module beat_cnt_ch
  import beat_cnt_pkg::*;
#(
  parameter int CNT_W  = 5,
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              beat_i,
  input  logic [CNT_W-1:0]  term_i,
  input  logic [1:0]        mode_i,
  output logic [CNT_W-1:0]  cnt_o,
  output logic              done_o,
  output logic              tc_pulse_o,
  output logic [WRAP_W-1:0] wrap_cnt_o
);

  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WRAP_W-1:0] WRAP_ONE = {{(WRAP_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [CNT_W-1:0]  term_q,  term_d;
  cnt_mode_e         mode_q,  mode_d;
  logic              fired_q, fired_d;
  logic [WRAP_W-1:0] wrap_q,  wrap_d;
  logic              tc_q,    tc_d;

  logic [CNT_W-1:0] cnt_inc;
  logic             at_term;
  logic             inc_hits_term;
  logic             wrap_full;

  assign cnt_inc       = cnt_q + CNT_ONE;
  assign at_term       = (cnt_q == term_q);
  assign inc_hits_term = (cnt_inc == term_q);
  assign wrap_full     = &wrap_q;

  always_comb begin
    cnt_d   = cnt_q;
    term_d  = term_q;
    mode_d  = mode_q;
    fired_d = fired_q;
    wrap_d  = wrap_q;
    tc_d    = 1'b0;

    if (clear_i) begin
      cnt_d   = '0;
      wrap_d  = '0;
      fired_d = 1'b0;
      term_d  = term_i;
      mode_d  = cnt_mode_e'(mode_i);
    end else if (beat_i) begin
      case (mode_q)
        MODE_WRAP: begin
          if (at_term) begin
            cnt_d = '0;
            tc_d  = 1'b1;
            if (!wrap_full) begin
              wrap_d = wrap_q + WRAP_ONE;
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
        MODE_ONESHOT: begin
          // A zero terminal count arms as already done: fire silently.
          if (!fired_q) begin
            if (at_term) begin
              fired_d = 1'b1;
            end else begin
              cnt_d   = cnt_inc;
              tc_d    = inc_hits_term;
              fired_d = inc_hits_term;
            end
          end
        end
        default: begin
          if (!at_term) begin
            cnt_d = cnt_inc;
            tc_d  = inc_hits_term;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      term_q  <= '1;
      mode_q  <= MODE_SAT;
      fired_q <= 1'b0;
      wrap_q  <= '0;
      tc_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      term_q  <= term_d;
      mode_q  <= mode_d;
      fired_q <= fired_d;
      wrap_q  <= wrap_d;
      tc_q    <= tc_d;
    end
  end

  assign cnt_o      = cnt_q;
  assign done_o     = at_term;
  assign tc_pulse_o = tc_q;
  assign wrap_cnt_o = wrap_q;

endmodule : beat_cnt_ch

// File: rtl/beat_counter_mc.sv
// Multi-channel handshake beat counter: NUM_CH independent channels with
// packed outputs and an all-channels-done flag.
module beat_counter_mc
  import beat_cnt_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 5,
  parameter int WRAP_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        cnt_enable,
  input  logic [NUM_CH-1:0]        cnt_clear,
  input  logic [NUM_CH-1:0]        valid,
  input  logic [NUM_CH-1:0]        ready,
  input  logic [CNT_W-1:0]         term_cnt,
  input  logic [1:0]               mode,
  output logic [NUM_CH*CNT_W-1:0]  cnt,
  output logic [NUM_CH-1:0]        cnt_done,
  output logic [NUM_CH-1:0]        tc_pulse,
  output logic [NUM_CH*WRAP_W-1:0] wrap_cnt,
  output logic                     all_done
);

  logic [NUM_CH-1:0] beat;

  assign beat = cnt_enable & valid & ready;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    beat_cnt_ch #(
      .CNT_W  (CNT_W),
      .WRAP_W (WRAP_W)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear_i    (cnt_clear[gi]),
      .beat_i     (beat[gi]),
      .term_i     (term_cnt),
      .mode_i     (mode),
      .cnt_o      (cnt[gi*CNT_W +: CNT_W]),
      .done_o     (cnt_done[gi]),
      .tc_pulse_o (tc_pulse[gi]),
      .wrap_cnt_o (wrap_cnt[gi*WRAP_W +: WRAP_W])
    );
  end

  assign all_done = &cnt_done;

endmodule : beat_counter_mc

// File: tb/tb_beat_counter_mc.sv
// Directed self-checking bench for beat_counter_mc.
module tb_beat_counter_mc;
  import beat_cnt_pkg::*;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 5;
  localparam int WRAP_W = 8;

  logic                     clk;
  logic                     rst_n;
  logic [NUM_CH-1:0]        cnt_enable;
  logic [NUM_CH-1:0]        cnt_clear;
  logic [NUM_CH-1:0]        valid;
  logic [NUM_CH-1:0]        ready;
  logic [CNT_W-1:0]         term_cnt;
  logic [1:0]               mode;
  logic [NUM_CH*CNT_W-1:0]  cnt;
  logic [NUM_CH-1:0]        cnt_done;
  logic [NUM_CH-1:0]        tc_pulse;
  logic [NUM_CH*WRAP_W-1:0] wrap_cnt;
  logic                     all_done;

  int vectors;
  int errors;

  beat_counter_mc #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .WRAP_W(WRAP_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cnt_enable (cnt_enable),
    .cnt_clear  (cnt_clear),
    .valid      (valid),
    .ready      (ready),
    .term_cnt   (term_cnt),
    .mode       (mode),
    .cnt        (cnt),
    .cnt_done   (cnt_done),
    .tc_pulse   (tc_pulse),
    .wrap_cnt   (wrap_cnt),
    .all_done   (all_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [CNT_W-1:0] cnt_of(input int ch);
    return cnt[ch*CNT_W +: CNT_W];
  endfunction

  function automatic logic [WRAP_W-1:0] wrap_of(input int ch);
    return wrap_cnt[ch*WRAP_W +: WRAP_W];
  endfunction

  task automatic clear_mask(input logic [NUM_CH-1:0] m, input logic [CNT_W-1:0] t,
                            input logic [1:0] md);
    cnt_clear = m;
    term_cnt  = t;
    mode      = md;
    @(posedge clk);
    #1;
    cnt_clear = '0;
    $display("clear mask=%b term=%0d mode=%0d", m, t, md);
  endtask

  task automatic beat_mask(input logic [NUM_CH-1:0] m);
    cnt_enable = m;
    valid      = m;
    ready      = m;
    @(posedge clk);
    #1;
    cnt_enable = '0;
    valid      = '0;
    ready      = '0;
    $display("beat mask=%b cnt=%h tc=%b done=%b", m, cnt, tc_pulse, cnt_done);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cnt_enable = '0; cnt_clear = '0; valid = '0; ready = '0;
    term_cnt = '0; mode = MODE_SAT;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (cnt !== '0 || wrap_cnt !== '0 || tc_pulse !== '0 || cnt_done !== '0 || all_done !== 1'b0) begin
      errors++;
      $display("FAIL reset: cnt=%h wrap=%h tc=%b done=%b all=%b, expected all zero",
               cnt, wrap_cnt, tc_pulse, cnt_done, all_done);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_sat();
    int pulses;
    pulses = 0;
    clear_mask(4'b0001, 5'd31, MODE_SAT);
    vectors++;
    if (cnt_done[0] !== 1'b0) begin
      errors++;
      $display("FAIL sat_done_early: got %b, expected 0", cnt_done[0]);
    end
    for (int b = 1; b <= 40; b++) begin
      beat_mask(4'b0001);
      vectors++;
      if (cnt_of(0) !== ((b < 31) ? b[CNT_W-1:0] : 5'd31)) begin
        errors++;
        $display("FAIL sat_cnt beat %0d: got %0d, expected %0d", b, cnt_of(0), (b < 31) ? b : 31);
      end
      vectors++;
      if (tc_pulse[0] !== (b == 31)) begin
        errors++;
        $display("FAIL sat_tc beat %0d: got %b, expected %b", b, tc_pulse[0], b == 31);
      end
      if (tc_pulse[0] === 1'b1) pulses++;
    end
    vectors++;
    if (pulses != 1 || cnt_done[0] !== 1'b1 || all_done !== 1'b0) begin
      errors++;
      $display("FAIL sat_summary: pulses=%0d done=%b all=%b, expected 1/1/0", pulses, cnt_done[0], all_done);
    end
  endtask

  task automatic test_wrap();
    clear_mask(4'b0010, 5'd3, MODE_WRAP);
    for (int b = 1; b <= 10; b++) begin
      beat_mask(4'b0010);
      vectors++;
      if (cnt_of(1) !== 5'(b % 4)) begin
        errors++;
        $display("FAIL wrap_cnt beat %0d: got %0d, expected %0d", b, cnt_of(1), b % 4);
      end
      vectors++;
      if (tc_pulse[1] !== (b % 4 == 0)) begin
        errors++;
        $display("FAIL wrap_tc beat %0d: got %b, expected %b", b, tc_pulse[1], b % 4 == 0);
      end
    end
    vectors++;
    if (wrap_of(1) !== 8'd2) begin
      errors++;
      $display("FAIL wrap_events: got %0d, expected 2", wrap_of(1));
    end
    vectors++;
    if (cnt_of(0) !== 5'd31) begin
      errors++;
      $display("FAIL wrap_isolation ch0: got %0d, expected 31", cnt_of(0));
    end
  endtask

  task automatic test_oneshot();
    for (int arm = 0; arm < 2; arm++) begin
      clear_mask(4'b0100, 5'd2, MODE_ONESHOT);
      vectors++;
      if (cnt_of(2) !== 5'd0) begin
        errors++;
        $display("FAIL os_clear arm %0d: got %0d, expected 0", arm, cnt_of(2));
      end
      for (int b = 1; b <= ((arm == 0) ? 5 : 2); b++) begin
        beat_mask(4'b0100);
        vectors++;
        if (cnt_of(2) !== ((b < 2) ? 5'd1 : 5'd2)) begin
          errors++;
          $display("FAIL os_cnt arm %0d beat %0d: got %0d, expected %0d", arm, b, cnt_of(2), (b < 2) ? 1 : 2);
        end
        vectors++;
        if (tc_pulse[2] !== (b == 2)) begin
          errors++;
          $display("FAIL os_tc arm %0d beat %0d: got %b, expected %b", arm, b, tc_pulse[2], b == 2);
        end
      end
    end
  endtask

  task automatic test_clear_priority();
    clear_mask(4'b1000, 5'd10, MODE_SAT);
    repeat (5) beat_mask(4'b1000);
    vectors++;
    if (cnt_of(3) !== 5'd5) begin
      errors++;
      $display("FAIL prio_pre: got %0d, expected 5", cnt_of(3));
    end
    // Clear and beat together, latching term=2 WRAP.
    cnt_clear = 4'b1000; cnt_enable = 4'b1000; valid = 4'b1000; ready = 4'b1000;
    term_cnt = 5'd2; mode = MODE_WRAP;
    @(posedge clk);
    #1;
    cnt_clear = '0; cnt_enable = '0; valid = '0; ready = '0;
    term_cnt = 5'd20; mode = MODE_SAT;
    $display("clear+beat ch3 cnt=%0d tc=%b", cnt_of(3), tc_pulse[3]);
    vectors++;
    if (cnt_of(3) !== 5'd0 || tc_pulse[3] !== 1'b0) begin
      errors++;
      $display("FAIL prio_clear: cnt=%0d tc=%b, expected 0/0", cnt_of(3), tc_pulse[3]);
    end
    for (int b = 1; b <= 3; b++) begin
      beat_mask(4'b1000);
      vectors++;
      if (cnt_of(3) !== 5'(b % 3) || tc_pulse[3] !== (b == 3)) begin
        errors++;
        $display("FAIL prio_latched beat %0d: cnt=%0d tc=%b, expected %0d/%b",
                 b, cnt_of(3), tc_pulse[3], b % 3, b == 3);
      end
    end
    vectors++;
    if (wrap_of(3) !== 8'd1) begin
      errors++;
      $display("FAIL prio_wrap: got %0d, expected 1", wrap_of(3));
    end
  endtask

  task automatic test_gating();
    clear_mask(4'b0001, 5'd4, MODE_SAT);
    cnt_enable = 4'b0001; valid = 4'b0001; ready = 4'b0000;
    repeat (4) @(posedge clk);
    #1;
    valid = 4'b0000; ready = 4'b0001;
    repeat (4) @(posedge clk);
    #1;
    cnt_enable = 4'b0000; valid = 4'b0001;
    repeat (4) @(posedge clk);
    #1;
    cnt_enable = '0; valid = '0; ready = '0;
    $display("gating ch0 cnt=%0d", cnt_of(0));
    vectors++;
    if (cnt_of(0) !== 5'd0) begin
      errors++;
      $display("FAIL gating: got %0d, expected 0", cnt_of(0));
    end
    clear_mask(4'b1111, 5'd2, MODE_SAT);
    beat_mask(4'b0111);
    vectors++;
    if (cnt !== {5'd0, 5'd1, 5'd1, 5'd1}) begin
      errors++;
      $display("FAIL indep_first: got %h, expected %h", cnt, {5'd0, 5'd1, 5'd1, 5'd1});
    end
    beat_mask(4'b0111);
    vectors++;
    if (cnt_done !== 4'b0111 || all_done !== 1'b0) begin
      errors++;
      $display("FAIL indep_three: done=%b all=%b, expected 0111/0", cnt_done, all_done);
    end
    beat_mask(4'b1000);
    vectors++;
    if (all_done !== 1'b0 || cnt_of(3) !== 5'd1) begin
      errors++;
      $display("FAIL indep_last_pre: all=%b cnt3=%0d, expected 0/1", all_done, cnt_of(3));
    end
    beat_mask(4'b1000);
    vectors++;
    if (all_done !== 1'b1 || cnt_done !== 4'b1111 || tc_pulse !== 4'b1000) begin
      errors++;
      $display("FAIL indep_all: all=%b done=%b tc=%b, expected 1/1111/1000", all_done, cnt_done, tc_pulse);
    end
  endtask

  task automatic test_async_reset();
    clear_mask(4'b0001, 5'd31, MODE_SAT);
    repeat (17) beat_mask(4'b0001);
    clear_mask(4'b0010, 5'd0, MODE_WRAP);
    for (int b = 1; b <= 3; b++) begin
      beat_mask(4'b0010);
      vectors++;
      if (tc_pulse[1] !== 1'b1 || cnt_of(1) !== 5'd0) begin
        errors++;
        $display("FAIL term0_wrap beat %0d: tc=%b cnt=%0d, expected 1/0", b, tc_pulse[1], cnt_of(1));
      end
    end
    vectors++;
    if (cnt_of(0) !== 5'd17 || wrap_of(1) !== 8'd3) begin
      errors++;
      $display("FAIL areset_pre: cnt0=%0d wrap1=%0d, expected 17/3", cnt_of(0), wrap_of(1));
    end
    cnt_enable = 4'b0001; valid = 4'b0001; ready = 4'b0001;
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (cnt !== '0 || wrap_cnt !== '0 || tc_pulse !== '0 || cnt_done !== '0 || all_done !== 1'b0) begin
      errors++;
      $display("FAIL areset_mid: cnt=%h wrap=%h tc=%b done=%b all=%b, expected all zero",
               cnt, wrap_cnt, tc_pulse, cnt_done, all_done);
    end
    cnt_enable = '0; valid = '0; ready = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int b = 1; b <= 32; b++) begin
      beat_mask(4'b0001);
      if (b >= 30) begin
        vectors++;
        if (cnt_done[0] !== (b >= 31) || tc_pulse[0] !== (b == 31)) begin
          errors++;
          $display("FAIL areset_term beat %0d: done=%b tc=%b, expected %b/%b",
                   b, cnt_done[0], tc_pulse[0], b >= 31, b == 31);
        end
      end
    end
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    test_reset();
    test_sat();
    test_wrap();
    test_oneshot();
    test_clear_priority();
    test_gating();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule : tb_beat_counter_mc
